// File: rtl/phy_tx_serializer_if.sv
// Byte-in / serial-out bundle between the transmit mux tree and the serializer.
// The master side offers bytes and watches the serial line; the slave side is the serializer.
interface phy_tx_serializer_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       byte_ack;
    logic       active;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  byte_ack,
        input  active
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output byte_ack,
        output active
    );
endinterface

// File: rtl/phy_tx_serializer.sv
// Byte-to-bit serializer: sends INIT_COM COM symbols after reset, then data or IDLE, MSB first.
// A symbol is loaded whenever the 3-bit bit counter is 0, so symbols run back-to-back.
module phy_tx_serializer #(
    parameter int         DATA_W      = 8,
    parameter logic [7:0] COM_SYMBOL  = 8'hBC,
    parameter logic [7:0] IDLE_SYMBOL = 8'h7C,
    parameter int         INIT_COM    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    phy_tx_serializer_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int COM_W = $clog2(INIT_COM + 1);
    localparam logic [COM_W-1:0] COM_LAST = COM_W'(INIT_COM - 1);

    typedef enum logic {
        ST_INIT,
        ST_ACTIVE
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [COM_W-1:0] com_cnt_q,  com_cnt_d;
    logic [7:0]       sr_q,       sr_d;
    logic             data_out_q, data_out_d;
    logic             byte_ack_q, byte_ack_d;
    logic             active_q,   active_d;
    logic [7:0]       sym;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        com_cnt_d  = com_cnt_q;
        sr_d       = sr_q;
        data_out_d = sr_q[3'd7 - cnt_q];
        byte_ack_d = 1'b0;
        active_d   = active_q;
        sym        = IDLE_SYMBOL;

        if (cnt_q == '0) begin
            // Input byte is only looked at here; between loads it may glitch freely.
            unique case (state_q)
                ST_INIT: begin
                    sym       = COM_SYMBOL;
                    com_cnt_d = com_cnt_q + 1'b1;
                    if (com_cnt_q == COM_LAST)
                        state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    active_d = 1'b1;
                    if (bus.valid_in) begin
                        sym        = bus.data_in;
                        byte_ack_d = 1'b1;
                    end
                end
                default: sym = IDLE_SYMBOL;
            endcase
            data_out_d = sym[7];
            sr_d       = sym;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            com_cnt_q  <= '0;
            sr_q       <= '0;
            data_out_q <= 1'b0;
            byte_ack_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            com_cnt_q  <= com_cnt_d;
            sr_q       <= sr_d;
            data_out_q <= data_out_d;
            byte_ack_q <= byte_ack_d;
            active_q   <= active_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.byte_ack = byte_ack_q;
    assign bus.active   = active_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Self-checking bench for phy_tx_serializer: per-slot symbol model checked bit by bit.
module tb_phy_tx_serializer;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;
    localparam int         NCOM = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   slot_idx;

    phy_tx_serializer_if bus ();

    phy_tx_serializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // One symbol slot starting at a load edge. Expected symbol comes from the slot number
    // since reset and the offered byte. abort_at >= 0 asserts reset after that bit.
    task automatic run_slot(input logic v, input logic [7:0] d, input logic glitch, input int abort_at);
        logic [7:0] exp_sym;
        logic       exp_ack, exp_act, exp_bit;
        if (slot_idx < NCOM) begin
            exp_sym = COM;
            exp_ack = 1'b0;
            exp_act = 1'b0;
        end else begin
            exp_sym = v ? d : IDLE;
            exp_ack = v;
            exp_act = 1'b1;
        end
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_bit = (exp_sym >> (7 - k)) & 8'd1;
            n_cmp++;
            if (bus.data_out !== exp_bit) begin
                n_err++;
                $display("FAIL data_out slot %0d bit %0d: got %b required %b", slot_idx, k, bus.data_out, exp_bit);
            end
            n_cmp++;
            if (bus.byte_ack !== (exp_ack && k == 0)) begin
                n_err++;
                $display("FAIL byte_ack slot %0d bit %0d: got %b required %b", slot_idx, k, bus.byte_ack, exp_ack && k == 0);
            end
            n_cmp++;
            if (bus.active !== exp_act) begin
                n_err++;
                $display("FAIL active slot %0d bit %0d: got %b required %b", slot_idx, k, bus.active, exp_act);
            end
            if (glitch) begin
                bus.data_in  = 8'h55;
                bus.valid_in = 1'b1;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                n_cmp++;
                if ({bus.data_out, bus.byte_ack, bus.active} !== 3'b000) begin
                    n_err++;
                    $display("FAIL abort_reset: got %b%b%b required 000", bus.data_out, bus.byte_ack, bus.active);
                end
                reset    = 1'b0;
                slot_idx = 0;
                return;
            end
            if (k < 7) @(posedge clk);
        end
        slot_idx++;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({bus.data_out, bus.byte_ack, bus.active} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %b%b%b required 000", i, bus.data_out, bus.byte_ack, bus.active);
            end
        end
        reset    = 1'b0;
        slot_idx = 0;
    endtask

    task automatic test_init_drop();
        for (int i = 0; i < NCOM; i++) run_slot(1'b1, 8'hFF, 1'b0, -1);
    endtask

    task automatic test_single();
        run_slot(1'b1, 8'hA5, 1'b0, -1);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) run_slot(1'b0, 8'h00, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_slot(1'b1, 8'h01, 1'b1, -1);
        run_slot(1'b1, 8'h80, 1'b1, -1);
        run_slot(1'b1, 8'h3C, 1'b1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_slot(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), -1);
    endtask

    task automatic test_mid_reset();
        run_slot(1'b1, 8'hC3, 1'b0, 3);
        for (int i = 0; i < NCOM; i++) run_slot(1'b1, 8'($urandom), 1'b0, -1);
        run_slot(1'b1, 8'h96, 1'b0, -1);
        run_slot(1'b0, 8'h00, 1'b0, -1);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        slot_idx = 0;
        reset    = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        test_reset();
        test_init_drop();
        test_single();
        test_idle();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phy_tx_serializer.md
Name: phy_tx_serializer

Overview:
- Parallel-to-serial stage directly downstream of the 4-lane transmit mux tree.
- Consumes the muxed byte stream (data plus valid, one byte per clk_4f period) and drives a 1-bit serial line, MSB first.
- After reset it sends a fixed number of COM alignment symbols before passing data.
- Whenever no valid byte is offered, it inserts an IDLE symbol, so the line is never left unframed.

Parameters:
- DATA_W, 8, symbol width in bits. The design is fixed at 8; the parameter exists for the counter-width derivation only.
- COM_SYMBOL, 8'hBC, alignment symbol sent during initialization.
- IDLE_SYMBOL, 8'h7C, filler symbol sent in ACTIVE state when valid_in is low.
- INIT_COM, 4, number of COM symbols sent after reset before ACTIVE (must be >= 1).

Ports:
- clk  in  1  bit-rate clock (8x clk_4f, rising edges aligned with clk_4f).
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  muxed byte from the transmit mux tree.
- valid_in  in  1  data_in holds a valid byte.
- data_out  out  1  serial output, MSB first, registered.
- byte_ack  out  1  one-cycle pulse: data_in was consumed at this load.
- active  out  1  high once initialization is complete (ACTIVE state).

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: data_out=0, byte_ack=0, active=0, bit counter cnt=0, COM counter=0, shift register=0, state=INIT.
- cnt is 3 bits, 0..7, free-running after reset, wraps 7->0. The load edge is every edge with reset=0 and cnt==0.
- On a load edge:
  - sym is selected per state (below).
  - data_out <= sym[7], sr <= sym, cnt <= 1.
- On edge with cnt==k (k=1..7): data_out <= sr[7-k]; cnt <= k+1 (7 wraps to 0).
- Latency: bit 7 of a symbol appears on data_out for the cycle following its load edge. A full symbol occupies 8 consecutive cycles; symbols are back-to-back with no gaps.
- data_in and valid_in are sampled only on load edges and ignored at all other edges. Upstream holds them for a full clk_4f period, which spans the load edge.
- State INIT:
  - sym = COM_SYMBOL; com_cnt increments on each load edge.
  - byte_ack stays 0 and valid_in is ignored; bytes offered during INIT are dropped.
  - On the load edge that loads the INIT_COM-th COM, state <= ACTIVE.
- State ACTIVE:
  - If valid_in=1: sym = data_in, and byte_ack <= 1 for that edge only (high during the cycle the MSB is on data_out).
  - If valid_in=0: sym = IDLE_SYMBOL and byte_ack <= 0.
  - byte_ack <= 0 on all non-load edges.
- active <= 1 on the first load edge executed in ACTIVE state, and stays 1 until reset.
- com_cnt width is clog2(INIT_COM+1); it saturates (holds) once ACTIVE.
- Reset mid-symbol: the current symbol is aborted. The next edge produces reset values, and after reset deasserts a fresh INIT sequence starts at cnt==0. No partial symbol is resumed.
- Reset held for multiple cycles: outputs stay at reset values throughout.
- No backpressure: the block always consumes at a rate of one symbol per 8 clk; valid_in=0 is the only flow control.

Test Plan:
- Reset for 3 cycles, then release -> data_out, byte_ack, active all 0 during reset. The first 32 serial bits are 4x 1011_1100 (0xBC), active=0 and byte_ack=0 throughout.
- After INIT, valid_in=1, data_in=8'hA5 held across one load edge -> bits 1010_0101 on the next 8 cycles. byte_ack=1 for exactly the first of those cycles; active=1 from the same cycle.
- After INIT, valid_in=0 -> 0111_1100 (0x7C) repeated, byte_ack never asserted.
- valid_in=1, data_in=8'hFF during INIT -> still only 0xBC symbols are sent, no byte_ack. The first data symbol is the byte present at the first ACTIVE load edge.
- Back-to-back 8'h01, 8'h80, 8'h3C, each held one clk_4f period, with data_in toggling to 8'h55 between load edges -> the serial stream is exactly 0000_0001 1000_0000 0011_1100 and the 8'h55 glitches are never sampled. Three byte_ack pulses occur, 8 cycles apart.
- Assert reset for 1 cycle at cnt==4 of a data symbol -> data_out=0 and active=0 on the next cycle. The symbol is aborted and a full 4-COM INIT sequence restarts before any data.
